// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch path.
// Fetch requests are accepted over a valid/ready channel under a credit limit.
// The word array is read in the accept cycle, and the result moves through a
// fixed-latency shift register. It then waits in a small FIFO until the
// consumer takes it, so responses leave in request order and are never lost.
// A separate load port fills the array before fetching starts.
module imem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2,
    parameter int          BUF_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam int          PTR_W = $clog2(BUF_DEPTH);
    localparam int          CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0] mem [DEPTH_WORDS];

    // A 33-bit difference makes an address below BASE_ADDR wrap to a huge value.
    // One compare against SPAN then covers both out-of-range directions.
    logic [32:0]      req_diff;
    logic             req_err;
    logic [IDX_W-1:0] req_idx;
    logic [31:0]      req_instr;
    logic             accept;

    logic [32:0]      wr_diff;
    logic             wr_ok;
    logic [IDX_W-1:0] wr_idx;

    logic             started;
    logic [CNT_W-1:0] outstanding;

    logic [LATENCY-1:0]        pipe_valid;
    logic [LATENCY-1:0][31:0]  pipe_instr;
    logic [LATENCY-1:0][31:0]  pipe_addr;
    logic [LATENCY-1:0]        pipe_err;

    logic [BUF_DEPTH-1:0][31:0] fifo_instr;
    logic [BUF_DEPTH-1:0][31:0] fifo_addr;
    logic [BUF_DEPTH-1:0]       fifo_err;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W:0]             fifo_count;

    logic push;
    logic pop;

    assign req_diff  = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign req_err   = (req_addr[1:0] != 2'b00) || (req_diff >= SPAN);
    assign req_idx   = IDX_W'(req_diff >> 2);
    assign req_instr = req_err ? NOP : mem[req_idx];

    assign wr_diff = {1'b0, wr_addr} - {1'b0, BASE_ADDR};
    assign wr_ok   = wr_en && (wr_addr[1:0] == 2'b00) && (wr_diff < SPAN);
    assign wr_idx  = IDX_W'(wr_diff >> 2);

    // Credits cover the pipeline and the FIFO together, so a push can never find the FIFO full.
    assign req_ready = started && (outstanding < CNT_W'(BUF_DEPTH));
    assign accept    = req_valid && req_ready;

    assign push = pipe_valid[LATENCY-1];
    assign pop  = rsp_valid && rsp_ready;

    // The FIFO head drives the outputs; an empty FIFO shows all zeros.
    assign rsp_valid = (fifo_count != '0);
    assign rsp_instr = rsp_valid ? fifo_instr[rd_ptr] : '0;
    assign rsp_addr  = rsp_valid ? fifo_addr[rd_ptr]  : '0;
    assign rsp_err   = rsp_valid ? fifo_err[rd_ptr]   : 1'b0;

    // Load-port write. The array has no reset, so its contents survive one.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Hold off requests until the first rising edge after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // Read pipeline. Stage 0 captures the pre-write array value in the accept cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= '0;
            pipe_instr <= '0;
            pipe_addr  <= '0;
            pipe_err   <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_instr[0] <= req_instr;
            pipe_addr[0]  <= req_addr;
            pipe_err[0]   <= req_err;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_instr[i] <= pipe_instr[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
        end
    end

    // FIFO payload storage. The outputs ignore it while the FIFO is empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= pipe_instr[LATENCY-1];
            fifo_addr[wr_ptr]  <= pipe_addr[LATENCY-1];
            fifo_err[wr_ptr]   <= pipe_err[LATENCY-1];
        end
    end

    // FIFO pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Outstanding credit count: requests in the pipeline plus entries in the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder with the default parameters
// (256 words, base 0, latency 2, FIFO depth 4).
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [31:0] boot_words [4];

    imem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // Free-running clock with a 10 ns period
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load-port write
    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // One request held for a single cycle; the caller makes sure the responder is idle
    task automatic issue_one(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
    endtask

    // Bounded wait for rsp_valid
    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (rsp_valid) got = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) load_word(32'(i * 4), boot_words[i]);
        n_compared++; if (req_ready !== 1'b0) begin n_mismatched++;
            $display("[TB] FAIL reset_req_ready: got %0b expected 0", req_ready); end
        n_compared++; if (rsp_valid !== 1'b0) begin n_mismatched++;
            $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        n_compared++; if (rsp_instr !== 32'h0) begin n_mismatched++;
            $display("[TB] FAIL reset_rsp_instr: got %h expected 0", rsp_instr); end
        n_compared++; if (rsp_addr !== 32'h0) begin n_mismatched++;
            $display("[TB] FAIL reset_rsp_addr: got %h expected 0", rsp_addr); end
        n_compared++; if (rsp_err !== 1'b0) begin n_mismatched++;
            $display("[TB] FAIL reset_rsp_err: got %0b expected 0", rsp_err); end
        reset = 1'b1;
        #1;
        n_compared++; if (req_ready !== 1'b0) begin n_mismatched++;
            $display("[TB] FAIL release_before_edge_ready: got %0b expected 0", req_ready); end
        tick();
        n_compared++; if (req_ready !== 1'b1) begin n_mismatched++;
            $display("[TB] FAIL release_after_edge_ready: got %0b expected 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        n_compared++; if (req_ready !== 1'b1) begin n_mismatched++;
            $display("[TB] FAIL b2b_ready: got %0b expected 1", req_ready); end
        // Accepts occur at edges N..N+3, so word k should be visible right after edge N+k+2
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 4);
            req_addr  = 32'(k * 4);
            tick();
            if (k >= 2 && k <= 5) begin
                n_compared++; if (rsp_valid !== 1'b1) begin n_mismatched++;
                    $display("[TB] FAIL b2b_valid_%0d: got %0b expected 1", k, rsp_valid); end
                n_compared++; if (rsp_instr !== boot_words[k-2]) begin n_mismatched++;
                    $display("[TB] FAIL b2b_instr_%0d: got %h expected %h", k, rsp_instr, boot_words[k-2]); end
                n_compared++; if (rsp_addr !== 32'((k - 2) * 4)) begin n_mismatched++;
                    $display("[TB] FAIL b2b_addr_%0d: got %h expected %h", k, rsp_addr, 32'((k - 2) * 4)); end
                n_compared++; if (rsp_err !== 1'b0) begin n_mismatched++;
                    $display("[TB] FAIL b2b_err_%0d: got %0b expected 0", k, rsp_err); end
            end else begin
                n_compared++; if (rsp_valid !== 1'b0) begin n_mismatched++;
                    $display("[TB] FAIL b2b_idle_valid_%0d: got %0b expected 0", k, rsp_valid); end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int n_acc;
        n_acc = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1;
            req_addr  = 32'(n_acc * 4);
            if (req_ready) n_acc++;
            tick();
        end
        req_valid = 1'b0;
        n_compared++; if (n_acc != 4) begin n_mismatched++;
            $display("[TB] FAIL bp_accepted: got %0d expected 4", n_acc); end
        n_compared++; if (req_ready !== 1'b0) begin n_mismatched++;
            $display("[TB] FAIL bp_ready_full: got %0b expected 0", req_ready); end
        n_compared++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'h0) begin n_mismatched++;
            $display("[TB] FAIL bp_head_frozen: got valid %0b addr %h expected 1 addr 0", rsp_valid, rsp_addr); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_compared++; if (rsp_valid !== 1'b1) begin n_mismatched++;
                $display("[TB] FAIL bp_drain_valid_%0d: got %0b expected 1", i, rsp_valid); end
            n_compared++; if (rsp_addr !== 32'(i * 4)) begin n_mismatched++;
                $display("[TB] FAIL bp_drain_addr_%0d: got %h expected %h", i, rsp_addr, 32'(i * 4)); end
            n_compared++; if (rsp_instr !== boot_words[i]) begin n_mismatched++;
                $display("[TB] FAIL bp_drain_instr_%0d: got %h expected %h", i, rsp_instr, boot_words[i]); end
            tick();
            if (i == 0) begin
                n_compared++; if (req_ready !== 1'b1) begin n_mismatched++;
                    $display("[TB] FAIL bp_ready_after_pop: got %0b expected 1", req_ready); end
            end
        end
        n_compared++; if (rsp_valid !== 1'b0) begin n_mismatched++;
            $display("[TB] FAIL bp_empty: got %0b expected 0", rsp_valid); end
    endtask

    task automatic test_errors();
        bit got;
        rsp_ready = 1'b1;
        issue_one(32'h6);
        wait_rsp(got);
        n_compared++; if (!got) begin n_mismatched++;
            $display("[TB] FAIL err_misaligned_timeout: got none expected response"); end
        n_compared++; if (rsp_err !== 1'b1 || rsp_instr !== 32'h13 || rsp_addr !== 32'h6) begin n_mismatched++;
            $display("[TB] FAIL err_misaligned: got err %0b instr %h addr %h expected 1 00000013 00000006", rsp_err, rsp_instr, rsp_addr); end
        tick();
        issue_one(32'h400);
        wait_rsp(got);
        n_compared++; if (rsp_err !== 1'b1 || rsp_instr !== 32'h13 || rsp_addr !== 32'h400) begin n_mismatched++;
            $display("[TB] FAIL err_range: got err %0b instr %h addr %h expected 1 00000013 00000400", rsp_err, rsp_instr, rsp_addr); end
        tick();
        issue_one(32'h3FC);
        wait_rsp(got);
        n_compared++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_addr !== 32'h3FC) begin n_mismatched++;
            $display("[TB] FAIL err_last_word: got valid %0b err %0b addr %h expected 1 0 000003fc", rsp_valid, rsp_err, rsp_addr); end
        tick();
    endtask

    task automatic test_collision();
        bit got;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h4;
        wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b0; wr_en = 1'b0;
        wait_rsp(got);
        n_compared++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0010_0113) begin n_mismatched++;
            $display("[TB] FAIL collide_old: got valid %0b instr %h expected 1 00100113", rsp_valid, rsp_instr); end
        tick();
        // These writes are illegal and must leave the array untouched
        load_word(32'h5, 32'hBAD0_0002);
        load_word(32'h400, 32'hBAD0_0001);
        issue_one(32'h4);
        wait_rsp(got);
        n_compared++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'hDEAD_BEEF) begin n_mismatched++;
            $display("[TB] FAIL collide_new: got valid %0b instr %h expected 1 deadbeef", rsp_valid, rsp_instr); end
        tick();
    endtask

    task automatic test_reset_midop();
        bit got;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i * 4);
            tick();
        end
        req_valid = 1'b0;
        n_compared++; if (rsp_valid !== 1'b1) begin n_mismatched++;
            $display("[TB] FAIL midop_pre_valid: got %0b expected 1", rsp_valid); end
        #2 reset = 1'b0;
        #1;
        n_compared++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_instr !== 32'h0) begin n_mismatched++;
            $display("[TB] FAIL midop_async: got valid %0b ready %0b instr %h expected 0 0 0", rsp_valid, req_ready, rsp_instr); end
        tick();
        tick();
        reset = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_compared++; if (rsp_valid !== 1'b0) begin n_mismatched++;
                $display("[TB] FAIL midop_stale_%0d: got %0b expected 0", i, rsp_valid); end
        end
        issue_one(32'h0);
        wait_rsp(got);
        n_compared++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0000_0093 || rsp_addr !== 32'h0 || rsp_err !== 1'b0) begin n_mismatched++;
            $display("[TB] FAIL midop_mem_kept: got valid %0b instr %h addr %h err %0b expected 1 00000093 0 0", rsp_valid, rsp_instr, rsp_addr, rsp_err); end
        tick();
    endtask

    task automatic test_alternate();
        int n_sent;
        int n_recv;
        int max_out;
        n_sent = 0; n_recv = 0; max_out = 0;
        for (int i = 0; i < 16; i++) load_word(32'(i * 4), 32'hC0DE_0000 + 32'(i * 32'h0101));
        for (int cyc = 0; cyc < 300 && n_recv < 16; cyc++) begin
            rsp_ready = (cyc % 2 == 0);
            req_valid = (n_sent < 16);
            req_addr  = 32'(n_sent * 4);
            if (rsp_valid && rsp_ready) begin
                n_compared++; if (rsp_addr !== 32'(n_recv * 4) || rsp_err !== 1'b0) begin n_mismatched++;
                    $display("[TB] FAIL alt_addr_%0d: got addr %h err %0b expected %h 0", n_recv, rsp_addr, rsp_err, 32'(n_recv * 4)); end
                n_compared++; if (rsp_instr !== 32'hC0DE_0000 + 32'(n_recv * 32'h0101)) begin n_mismatched++;
                    $display("[TB] FAIL alt_instr_%0d: got %h expected %h", n_recv, rsp_instr, 32'hC0DE_0000 + 32'(n_recv * 32'h0101)); end
                n_recv++;
            end
            if (req_valid && req_ready) n_sent++;
            if (n_sent - n_recv > max_out) max_out = n_sent - n_recv;
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n_compared++; if (n_recv != 16) begin n_mismatched++;
            $display("[TB] FAIL alt_count: got %0d expected 16", n_recv); end
        n_compared++; if (max_out > 4) begin n_mismatched++;
            $display("[TB] FAIL alt_outstanding: got %0d expected at most 4", max_out); end
        tick();
        tick();
        n_compared++; if (rsp_valid !== 1'b0) begin n_mismatched++;
            $display("[TB] FAIL alt_no_dup: got %0b expected 0", rsp_valid); end
    endtask

    // Runs each scenario in order, then prints the summary line
    initial begin
        boot_words[0] = 32'h0000_0093;
        boot_words[1] = 32'h0010_0113;
        boot_words[2] = 32'h0020_0193;
        boot_words[3] = 32'h0030_0213;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_collision();
        test_reset_midop();
        test_alternate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
